udbcd_step_arb: RTL and testbench

UDBCD_STEP_ARB -- requirements
Module: udbcd_step_arb

---
 rtl/udbcd_step_arb.sv | 146 ++++++++++++++
 tb/tb_udbcd_step_arb.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/udbcd_step_arb.sv
// Two-requester round-robin arbiter driving a two-digit BCD up/down counter,
// one step per granted request, paced by a DIV-cycle prescaler.
module udbcd_step_arb #(
  parameter int DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_up,
  input  logic       req_dn,
  input  logic       hold,
  output logic       ack_up,
  output logic       ack_dn,
  output logic       busy,
  output logic [7:0] c_out,
  output logic       carry
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_TICK,
    STEP,
    ACK
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] presc_q, presc_d;
  logic       dir_dn_q, dir_dn_d;
  logic       last_dn_q, last_dn_d;
  logic [7:0] cnt_q, cnt_d;
  logic       ack_up_q, ack_up_d;
  logic       ack_dn_q, ack_dn_d;
  logic       busy_q, busy_d;
  logic       carry_q, carry_d;

  logic [3:0] ones, tens;
  logic [3:0] ones_nx, tens_nx;
  logic       wrap_nx;

  assign ones = cnt_q[3:0];
  assign tens = cnt_q[7:4];

  // BCD increment/decrement of the current count in the latched direction
  always_comb begin
    ones_nx = ones;
    tens_nx = tens;
    wrap_nx = 1'b0;
    if (!dir_dn_q) begin
      if (ones == 4'd9) begin
        ones_nx = 4'd0;
        if (tens == 4'd9) begin
          tens_nx = 4'd0;
          wrap_nx = 1'b1;
        end else begin
          tens_nx = tens + 4'd1;
        end
      end else begin
        ones_nx = ones + 4'd1;
      end
    end else begin
      if (ones == 4'd0) begin
        ones_nx = 4'd9;
        if (tens == 4'd0) begin
          tens_nx = 4'd9;
          wrap_nx = 1'b1;
        end else begin
          tens_nx = tens - 4'd1;
        end
      end else begin
        ones_nx = ones - 4'd1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    dir_dn_d  = dir_dn_q;
    last_dn_d = last_dn_q;
    cnt_d     = cnt_q;
    carry_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!hold && (req_up || req_dn)) begin
          state_d  = WAIT_TICK;
          presc_d  = '0;
          // on contention, serve whichever side did not go last
          dir_dn_d = (req_up && req_dn) ? !last_dn_q : req_dn;
        end
      end
      WAIT_TICK: begin
        if (!hold) begin
          if (presc_q == 4'(DIV - 1)) begin
            state_d = STEP;
          end else begin
            presc_d = presc_q + 4'd1;
          end
        end
      end
      STEP: begin
        cnt_d   = {tens_nx, ones_nx};
        carry_d = wrap_nx;
        state_d = ACK;
      end
      ACK: begin
        last_dn_d = dir_dn_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // outputs are registered against the upcoming state
    busy_d   = (state_d != IDLE);
    ack_up_d = (state_d == ACK) && !dir_dn_q;
    ack_dn_d = (state_d == ACK) && dir_dn_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      dir_dn_q  <= 1'b0;
      last_dn_q <= 1'b1;
      cnt_q     <= '0;
      ack_up_q  <= 1'b0;
      ack_dn_q  <= 1'b0;
      busy_q    <= 1'b0;
      carry_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      dir_dn_q  <= dir_dn_d;
      last_dn_q <= last_dn_d;
      cnt_q     <= cnt_d;
      ack_up_q  <= ack_up_d;
      ack_dn_q  <= ack_dn_d;
      busy_q    <= busy_d;
      carry_q   <= carry_d;
    end
  end

  assign ack_up = ack_up_q;
  assign ack_dn = ack_dn_q;
  assign busy   = busy_q;
  assign c_out  = cnt_q;
  assign carry  = carry_q;

endmodule

// File: tb/tb_udbcd_step_arb.sv
// Directed bench for udbcd_step_arb with DIV=4: latency, BCD wrap/carry,
// round-robin order, hold behaviour and reset mid-operation.
module tb_udbcd_step_arb;

  logic       clk;
  logic       rst;
  logic       req_up;
  logic       req_dn;
  logic       hold;
  logic       ack_up;
  logic       ack_dn;
  logic       busy;
  logic [7:0] c_out;
  logic       carry;

  int checks;
  int failures;

  udbcd_step_arb #(.DIV(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .req_up (req_up),
    .req_dn (req_dn),
    .hold   (hold),
    .ack_up (ack_up),
    .ack_dn (ack_dn),
    .busy   (busy),
    .c_out  (c_out),
    .carry  (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; req_up = 1'b0; req_dn = 1'b0; hold = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
  endtask

  // One request until its ack; returns cycles from the sampling edge to the ack cycle.
  task automatic do_op(input logic up, input logic drop_early, output int cyc,
                       output logic seen, output logic cy, output int stray);
    cyc = 0; seen = 1'b0; cy = 1'b0; stray = 0;
    if (up) req_up = 1'b1; else req_dn = 1'b1;
    while (!seen && cyc < 50) begin
      tick();
      cyc++;
      if (drop_early && cyc == 1) begin
        req_up = 1'b0; req_dn = 1'b0;
      end
      if ((up && ack_up) || (!up && ack_dn)) begin
        seen = 1'b1;
        cy = carry;
        if (up ? ack_dn : ack_up) stray++;
      end else if (ack_up || ack_dn || carry) begin
        stray++;
      end
    end
    req_up = 1'b0; req_dn = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (c_out !== 8'h00) begin failures++; $display("FAIL reset_c_out got=%h exp=00", c_out); end
    checks++;
    if ({busy, ack_up, ack_dn, carry} !== 4'b0000) begin
      failures++; $display("FAIL reset_flags got=%b exp=0000", {busy, ack_up, ack_dn, carry});
    end
    repeat (2) tick();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_latency();
    int bad;
    bad = 0;
    req_up = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL lat_busy_c1 got=%b exp=1", busy); end
    for (int c = 2; c <= 5; c++) begin
      tick();
      if (busy !== 1'b1 || ack_up !== 1'b0 || ack_dn !== 1'b0 || c_out !== 8'h00) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL lat_wait_cycles bad=%0d exp=0", bad); end
    tick();
    checks++;
    if (ack_up !== 1'b1 || ack_dn !== 1'b0 || carry !== 1'b0) begin
      failures++; $display("FAIL lat_ack_c6 got=%b%b%b exp=100", ack_up, ack_dn, carry);
    end
    checks++;
    if (c_out !== 8'h01) begin failures++; $display("FAIL lat_c_out got=%h exp=01", c_out); end
    req_up = 1'b0;
    tick();
    checks++;
    if (ack_up !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL lat_after_ack ack_up=%b busy=%b exp=0 0", ack_up, busy);
    end
  endtask

  task automatic test_wrap();
    int cyc, stray;
    logic seen, cy;
    logic [7:0] exp_c [3];
    logic       exp_cy [3];
    logic       dir_up [3];
    exp_c  = '{8'h00, 8'h99, 8'h00};
    exp_cy = '{1'b0, 1'b1, 1'b1};
    dir_up = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      do_op(dir_up[i], 1'b0, cyc, seen, cy, stray);
      checks++;
      if (seen !== 1'b1 || cyc != 6) begin
        failures++; $display("FAIL wrap%0d_ack seen=%b cyc=%0d exp=1 6", i, seen, cyc);
      end
      checks++;
      if (c_out !== exp_c[i]) begin failures++; $display("FAIL wrap%0d_c_out got=%h exp=%h", i, c_out, exp_c[i]); end
      checks++;
      if (cy !== exp_cy[i] || stray != 0) begin
        failures++; $display("FAIL wrap%0d_carry got=%b stray=%0d exp=%b 0", i, cy, stray, exp_cy[i]);
      end
    end
  endtask

  task automatic test_digit_carry();
    int cyc, stray;
    logic seen, cy;
    for (int i = 1; i <= 10; i++) begin
      do_op(1'b1, 1'b0, cyc, seen, cy, stray);
      checks++;
      if (seen !== 1'b1 || cy !== 1'b0 || stray != 0 || c_out !== ((i == 10) ? 8'h10 : 8'(i))) begin
        failures++;
        $display("FAIL count_up%0d got=%h seen=%b carry=%b stray=%0d", i, c_out, seen, cy, stray);
      end
    end
    do_op(1'b0, 1'b1, cyc, seen, cy, stray);
    checks++;
    if (seen !== 1'b1 || cyc != 6) begin
      failures++; $display("FAIL late_ack_dn seen=%b cyc=%0d exp=1 6", seen, cyc);
    end
    checks++;
    if (c_out !== 8'h09 || cy !== 1'b0 || stray != 0) begin
      failures++; $display("FAIL borrow_c_out got=%h carry=%b stray=%0d exp=09 0 0", c_out, cy, stray);
    end
  endtask

  task automatic test_reset_mid_step();
    req_up = 1'b1;
    repeat (5) tick();
    checks++;
    if (busy !== 1'b1 || c_out !== 8'h09) begin
      failures++; $display("FAIL step_pre busy=%b c_out=%h exp=1 09", busy, c_out);
    end
    rst = 1'b0; req_up = 1'b0;
    tick();
    checks++;
    if (c_out !== 8'h00 || {busy, ack_up, ack_dn, carry} !== 4'b0000) begin
      failures++; $display("FAIL step_reset c_out=%h flags=%b exp=00 0000", c_out, {busy, ack_up, ack_dn, carry});
    end
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if (c_out !== 8'h00 || {busy, ack_up, ack_dn} !== 3'b000) begin
      failures++; $display("FAIL step_discard c_out=%h flags=%b exp=00 000", c_out, {busy, ack_up, ack_dn});
    end
  endtask

  task automatic test_round_robin();
    int cnt;
    logic seen;
    logic [7:0] exp_c;
    logic exp_up;
    do_reset();
    req_up = 1'b1; req_dn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_up = (k % 2 == 0);
      exp_c  = exp_up ? 8'h01 : 8'h00;
      seen = 1'b0; cnt = 0;
      while (!seen && cnt < 50) begin
        tick();
        cnt++;
        if (ack_up || ack_dn) seen = 1'b1;
      end
      if (k == 3) begin req_up = 1'b0; req_dn = 1'b0; end
      checks++;
      if (ack_up !== exp_up || ack_dn !== !exp_up || carry !== 1'b0) begin
        failures++; $display("FAIL rr%0d_order up=%b dn=%b carry=%b exp=%b %b 0", k, ack_up, ack_dn, carry, exp_up, !exp_up);
      end
      checks++;
      if (c_out !== exp_c) begin failures++; $display("FAIL rr%0d_c_out got=%h exp=%h", k, c_out, exp_c); end
      checks++;
      if (cnt != ((k == 0) ? 6 : 7)) begin
        failures++; $display("FAIL rr%0d_spacing got=%0d exp=%0d", k, cnt, (k == 0) ? 6 : 7);
      end
    end
    repeat (2) tick();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL rr_idle busy=%b exp=0", busy); end
  endtask

  task automatic test_hold();
    int cnt, bad;
    logic seen, cy;
    bad = 0;
    req_up = 1'b1;
    tick();
    cnt = 1;
    hold = 1'b1;
    repeat (3) begin
      tick();
      cnt++;
      if (busy !== 1'b1 || ack_up !== 1'b0) bad++;
    end
    hold = 1'b0;
    while (!ack_up && cnt < 50) begin
      tick();
      cnt++;
    end
    req_up = 1'b0;
    checks++;
    if (cnt != 9 || bad != 0) begin failures++; $display("FAIL hold_delay got=%0d bad=%0d exp=9 0", cnt, bad); end
    checks++;
    if (c_out !== 8'h01) begin failures++; $display("FAIL hold_c_out got=%h exp=01", c_out); end
    tick();
    hold = 1'b1; req_dn = 1'b1;
    bad = 0;
    repeat (5) begin
      tick();
      if (busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL hold_idle_busy bad=%0d exp=0", bad); end
    hold = 1'b0;
    cnt = 0; seen = 1'b0; cy = 1'b0;
    while (!seen && cnt < 50) begin
      tick();
      cnt++;
      if (ack_dn) begin seen = 1'b1; cy = carry; end
    end
    req_dn = 1'b0;
    checks++;
    if (cnt != 6 || c_out !== 8'h00 || cy !== 1'b0) begin
      failures++; $display("FAIL hold_release cyc=%0d c_out=%h carry=%b exp=6 00 0", cnt, c_out, cy);
    end
    tick();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_latency();
    test_wrap();
    test_digit_carry();
    test_reset_mid_step();
    test_round_robin();
    test_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
